pipeline_ctrl_unit: RTL and testbench
=====================================

# pipeline_ctrl_unit

Stall/flush controller for the 5-stage RISC-V pipeline. Sits beside the forwarding logic and covers the hazards forwarding cannot resolve:
- detects load-use hazards between Decode and Execute;
- flushes wrong-path instructions on a taken branch/jump resolved in Execute;
- sequences a multi-cycle MUL/DIV unit in Execute with a start/done handshake, holding the front of the pipe until the result is ready.

## Interface
Parameters:
- MD_TIMEOUT, 64, max cycles in MD_BUSY before forced abort (≥2)
- CNT_W, 32, width of performance counters

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- MemReadE  in  1  Execute-stage instruction is a load
- RD_E  in  5  Execute-stage destination register
- Rs1_D, Rs2_D  in  5 each  Decode-stage source registers
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MulDivE  in  1  Execute-stage instruction is MUL/DIV
- md_done  in  1  MUL/DIV unit result valid, single-cycle pulse
- md_start  out  1  one-cycle start pulse to MUL/DIV unit
- md_abort  out  1  one-cycle pulse, timeout abort
- StallF, StallD, StallE  out  1 each  hold pipeline registers
- FlushD, FlushE, FlushM  out  1 each  clear pipeline registers to bubble
- perf_lw, perf_md, perf_flush  out  CNT_W each  performance counters (see Configuration)

## Operation
- lwStall = MemReadE & (RD_E != 0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D)).
- mdStall is asserted in two cases:
  - state MD_IDLE with MulDivE = 1;
  - state MD_BUSY.
- StallF = StallD = lwStall | mdStall.
- StallE = mdStall.
- FlushM = mdStall (bubble into Memory while Execute holds).
- FlushD = PCSrcE & !mdStall.
- FlushE = (lwStall | PCSrcE) & !mdStall.
- MulDivE and MemReadE/PCSrcE never coincide (decoder guarantee). mdStall has priority over everything else.

MUL/DIV FSM:
- MD_IDLE
  - MulDivE = 1: assert md_start, go to MD_BUSY, clear timer.
- MD_BUSY
  - timer increments each cycle.
  - md_done = 1: go to MD_DONE.
  - timer == MD_TIMEOUT-1 with no md_done: assert md_abort, go to MD_DONE.
- MD_DONE
  - all md stalls released; Execute advances with the result.
  - MulDivE is ignored this cycle, so there is no restart.
  - Always returns to MD_IDLE.
- Back-to-back MUL/DIV: the second instruction enters Execute in the cycle after MD_DONE and starts from MD_IDLE normally.

Other rules:
- md_done outside MD_BUSY is ignored.
- md_done in the same cycle as timeout: done wins, no abort.
- All outputs are 0 while rst = 0. State returns to MD_IDLE, timer and counters clear.
- Reset during MD_BUSY: aborts silently, no md_abort pulse. The MUL/DIV unit shares rst.

## Timing
- Load-use and branch outputs: combinational, same cycle as their inputs.
- md_start: exactly one cycle, in the first cycle MulDivE is seen in MD_IDLE.
- Minimum MUL/DIV occupancy: 3 cycles.
  - cycle 0: start;
  - cycle 1: MD_BUSY, md_done at earliest;
  - cycle 2: MD_DONE, stall released.
- md_done arriving k cycles after md_start releases stalls at cycle k+1.
- Timeout: md_abort is asserted in the cycle MD_BUSY has lasted MD_TIMEOUT cycles. Stall releases the next cycle.
- MUL/DIV unit requirements: must not assert md_done in the md_start cycle, and holds its result until the next md_start.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_lw counts cycles with lwStall.
  - perf_md counts cycles with mdStall.
  - perf_flush counts cycles with FlushD | FlushE.
  - All three wrap modulo 2^CNT_W and clear on reset.
- Undefined: the perf_* ports remain and are tied to 0, and no counter flops are built.

## Structure
- Package hazard_pkg holds:
  - md_state_t enum (MD_IDLE, MD_BUSY, MD_DONE);
  - REG_X0 = 5'h00;
  - the default MD_TIMEOUT.
- Sub-module md_sequencer holds the FSM, timeout timer, md_start/md_abort and mdStall. The top adds the combinational load-use/branch logic and the counters.

## Test plan
- Load x5 in E, Rs1_D = 5 → StallF = StallD = FlushE = 1 for one cycle. With RD_E = 0 → no stall.
- PCSrcE = 1 → FlushD = FlushE = 1, no stalls, same cycle.
- MulDivE = 1, md_done 4 cycles after md_start → md_start one cycle, StallF/D/E = FlushM = 1 for 5 cycles, released in MD_DONE, no second md_start.
- MD_TIMEOUT = 8, md_done never arrives → md_abort at the 8th MD_BUSY cycle, stall released the next cycle, FSM back in MD_IDLE.
- rst = 0 during MD_BUSY → all outputs 0 the next cycle, FSM in MD_IDLE. A later MulDivE issues a fresh md_start.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 taken branch + a 3-cycle MUL/DIV → perf_lw = 2, perf_flush = 3, perf_md = 2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

    // MUL/DIV sequencing states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Architectural zero register; a load targeting it never creates a hazard
    localparam logic [4:0] REG_X0 = 5'h00;

    // Default number of MD_BUSY cycles before the sequencer gives up on md_done
    localparam int MD_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/md_sequencer.sv
// MUL/DIV sequencer: start/done handshake with the multi-cycle unit in
// Execute, timeout abort, and the stall request that holds the front of the
// pipe while the unit is working. Reset is synchronous and active-low.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic mul_div_e,
    input  logic md_done,
    output logic md_start,
    output logic md_abort,
    output logic md_stall
);

    localparam int TIMER_W = $clog2(MD_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MD_TIMEOUT - 1);

    md_state_t          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Next-state, timer and handshake outputs; everything is forced quiet while reset is held
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        md_start = 1'b0;
        md_abort = 1'b0;
        md_stall = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (mul_div_e) begin
                    md_start = 1'b1;
                    md_stall = 1'b1;
                    timer_d  = '0;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_stall = 1'b1;
                timer_d  = timer_q + 1'b1;
                if (md_done) begin
                    state_d = MD_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    md_abort = 1'b1;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
        if (!rst) begin
            md_start = 1'b0;
            md_abort = 1'b0;
            md_stall = 1'b0;
        end
    end

    // State and timer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection,
// taken-branch flushing and MUL/DIV holding. mdStall overrides the other
// hazards. Optional performance counters are built only when
// HAZARD_PERF_CNT_EN is defined; otherwise the perf_* ports read 0.
module pipeline_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadE,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             md_done,
    output logic             md_start,
    output logic             md_abort,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [CNT_W-1:0] perf_lw,
    output logic [CNT_W-1:0] perf_md,
    output logic [CNT_W-1:0] perf_flush
);

    logic lw_stall;
    logic md_stall;
    logic branch_taken;

    md_sequencer #(
        .MD_TIMEOUT(MD_TIMEOUT)
    ) u_md_sequencer (
        .clk      (clk),
        .rst      (rst),
        .mul_div_e(MulDivE),
        .md_done  (md_done),
        .md_start (md_start),
        .md_abort (md_abort),
        .md_stall (md_stall)
    );

    // Hazard detection and stall/flush decode; md_stall already reads 0 during reset
    always_comb begin
        lw_stall     = rst & MemReadE & (RD_E != REG_X0) &
                       ((RD_E == Rs1_D) | (RD_E == Rs2_D));
        branch_taken = rst & PCSrcE;
        StallF       = lw_stall | md_stall;
        StallD       = lw_stall | md_stall;
        StallE       = md_stall;
        FlushM       = md_stall;
        FlushD       = branch_taken & ~md_stall;
        FlushE       = (lw_stall | branch_taken) & ~md_stall;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lw_q, perf_lw_d;
    logic [CNT_W-1:0] perf_md_q, perf_md_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    // Counter increments; the counters wrap naturally at 2^CNT_W
    always_comb begin
        perf_lw_d    = perf_lw_q + CNT_W'(lw_stall);
        perf_md_d    = perf_md_q + CNT_W'(md_stall);
        perf_flush_d = perf_flush_q + CNT_W'(FlushD | FlushE);
        perf_lw      = rst ? perf_lw_q : '0;
        perf_md      = rst ? perf_md_q : '0;
        perf_flush   = rst ? perf_flush_q : '0;
    end

    // Counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lw_q    <= '0;
            perf_md_q    <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_lw_q    <= perf_lw_d;
            perf_md_q    <= perf_md_d;
            perf_flush_q <= perf_flush_d;
        end
    end
`else
    assign perf_lw    = '0;
    assign perf_md    = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit (MD_TIMEOUT = 8). Inputs change 1 ns
// after the rising edge, outputs are compared on the falling edge.
module tb_pipeline_ctrl_unit;

    localparam int CNT_W = 32;

    // Expected control vectors: {md_start, md_abort, StallF, StallD, StallE, FlushD, FlushE, FlushM}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LW   = 8'b0011_0010;
    localparam logic [7:0] BR   = 8'b0000_0110;
    localparam logic [7:0] MDS  = 8'b1011_1001;
    localparam logic [7:0] MDB  = 8'b0011_1001;
    localparam logic [7:0] ABT  = 8'b0111_1001;

    logic             clk = 1'b0;
    logic             rst;
    logic             MemReadE;
    logic [4:0]       RD_E;
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic             PCSrcE;
    logic             MulDivE;
    logic             md_done;
    logic             md_start;
    logic             md_abort;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic [CNT_W-1:0] perf_lw;
    logic [CNT_W-1:0] perf_md;
    logic [CNT_W-1:0] perf_flush;
    logic [7:0]       outVec;

    int checkCount = 0;
    int errorCount = 0;

    pipeline_ctrl_unit #(
        .MD_TIMEOUT(8),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadE  (MemReadE),
        .RD_E      (RD_E),
        .Rs1_D     (Rs1_D),
        .Rs2_D     (Rs2_D),
        .PCSrcE    (PCSrcE),
        .MulDivE   (MulDivE),
        .md_done   (md_done),
        .md_start  (md_start),
        .md_abort  (md_abort),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushM    (FlushM),
        .perf_lw   (perf_lw),
        .perf_md   (perf_md),
        .perf_flush(perf_flush)
    );

    assign outVec = {md_start, md_abort, StallF, StallD, StallE, FlushD, FlushE, FlushM};

    // 10 ns clock
    always #5 clk = ~clk;

    // Drive one cycle worth of pipeline inputs
    task automatic applyStimulus(input logic mr, input logic [4:0] rde, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic pc, input logic mdv,
                                 input logic done);
        MemReadE = mr;
        RD_E     = rde;
        Rs1_D    = rs1;
        Rs2_D    = rs2;
        PCSrcE   = pc;
        MulDivE  = mdv;
        md_done  = done;
    endtask

    // Single comparison point: count it and report any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Apply inputs for one cycle, check the control vector mid-cycle, advance to next cycle
    task automatic driveCycle(input string tag, input logic mr, input logic [4:0] rde,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic pc,
                              input logic mdv, input logic done, input logic [7:0] exp);
        applyStimulus(mr, rde, rs1, rs2, pc, mdv, done);
        @(negedge clk);
        checkOutput(tag, {24'b0, outVec}, {24'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset: outputs silent even with hazard-looking inputs
        driveCycle("rst_lw",   1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, NONE);
        driveCycle("rst_md",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);
        rst = 1'b1;
        driveCycle("idle",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);

        // Load-use hazards
        driveCycle("lw_rs1",   1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, LW);
        driveCycle("lw_gone",  1'b0, 5'd0, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, NONE);
        driveCycle("lw_rs2",   1'b1, 5'd17, 5'd2, 5'd17, 1'b0, 1'b0, 1'b0, LW);
        driveCycle("lw_x0",    1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
        driveCycle("no_load",  1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, NONE);
        driveCycle("lw_miss",  1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, NONE);

        // Taken branch
        driveCycle("branch",   1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, BR);
        driveCycle("done_idle",1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, NONE);

        // MUL/DIV with md_done four cycles after md_start
        driveCycle("md_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        driveCycle("md_busy1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDB);
        driveCycle("md_busy2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDB);
        driveCycle("md_busy3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDB);
        driveCycle("md_busy4", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MDB);
        driveCycle("md_done",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);
        driveCycle("md_after", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);

        // Back-to-back minimum-latency MUL/DIV
        driveCycle("b2b_s1",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        driveCycle("b2b_b1",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MDB);
        driveCycle("b2b_d1",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);
        driveCycle("b2b_s2",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        driveCycle("b2b_b2",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MDB);
        driveCycle("b2b_d2",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);

        // Timeout: md_done never arrives, abort on the 8th busy cycle
        driveCycle("to_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        for (int i = 1; i < 8; i++) begin
            driveCycle($sformatf("to_busy%0d", i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDB);
        end
        driveCycle("to_abort", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, ABT);
        driveCycle("to_rel",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);
        driveCycle("to_idle",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);

        // md_done coinciding with the timeout cycle wins, no abort
        driveCycle("tw_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        for (int i = 1; i < 8; i++) begin
            driveCycle($sformatf("tw_busy%0d", i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDB);
        end
        driveCycle("tw_last",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MDB);
        driveCycle("tw_rel",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);

        // Reset in the middle of MD_BUSY, then a fresh start
        driveCycle("rb_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        driveCycle("rb_busy",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDB);
        rst = 1'b0;
        driveCycle("rb_rst",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);
        rst = 1'b1;
        driveCycle("rb_fresh", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        driveCycle("rb_busy2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MDB);
        driveCycle("rb_done",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);

        // Counter scenario from a clean reset: 2 load-use, 1 branch, 3-cycle MUL/DIV
        rst = 1'b0;
        driveCycle("pc_rst",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
        rst = 1'b1;
        driveCycle("pc_lw1",   1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0, LW);
        driveCycle("pc_lw2",   1'b1, 5'd4, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0, LW);
        driveCycle("pc_br",    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, BR);
        driveCycle("pc_mds",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MDS);
        driveCycle("pc_mdb",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MDB);
        driveCycle("pc_mdd",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, NONE);
        driveCycle("pc_idle",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_lw",    perf_lw,    32'd2);
        checkOutput("perf_flush", perf_flush, 32'd3);
        checkOutput("perf_md",    perf_md,    32'd2);
        rst = 1'b0;
        driveCycle("pc_clr",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
        rst = 1'b1;
        checkOutput("perf_md_clr", perf_md, 32'd0);
`else
        checkOutput("perf_lw_tied",    perf_lw,    32'd0);
        checkOutput("perf_flush_tied", perf_flush, 32'd0);
        checkOutput("perf_md_tied",    perf_md,    32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
